// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: load types, byte-enable
// patterns and the bus FSM states.
package mem_stage_pkg;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LW  = 3'd2;
  localparam logic [2:0] LOAD_LBU = 3'd4;
  localparam logic [2:0] LOAD_LHU = 3'd5;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    MEM_IDLE    = 1'b0,
    MEM_WAIT_RV = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the addressed byte lane out of the
// read word and sign- or zero-extends it according to the load type.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_op,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  // Bring the addressed lane down to bit 0 before extending.
  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_op)
      LOAD_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LOAD_LH:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LOAD_LW:  o_data = w_shifted;
      LOAD_LBU: o_data = {24'd0, w_shifted[7:0]};
      LOAD_LHU: o_data = {16'd0, w_shifted[15:0]};
      default:  o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the req/gnt/rvalid data bus, aligns
// store and load data, and registers the write-back triple.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            m_regfile_waddr_i,
  input  logic [DATA_WIDTH-1:0] m_regfile_rd_i,
  input  logic                  m_regfile_wr_i,
  input  logic                  m_data_wr_i,
  input  logic                  m_data_rd_i,
  input  logic                  m_is_load_store_i,
  input  logic [DATA_WIDTH-1:0] m_data_addr_i,
  input  logic [BE_WIDTH-1:0]   m_data_be_i,
  input  logic [2:0]            m_LOAD_op_i,
  input  logic                  stall_general_i,
  output logic                  mem_stall_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output logic [4:0]            w_regfile_waddr_o,
  output logic [DATA_WIDTH-1:0] w_regfile_wdata_o,
  output logic                  w_regfile_wr_o,
  output logic                  misaligned_o
);

  mem_state_e            r_state, w_state_nxt;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_load_buf;
  logic                  w_acc, w_mis, w_active, w_complete, w_is_load;
  logic [DATA_WIDTH-1:0] w_load_data, w_wb_data;

  assign w_acc = m_is_load_store_i & (m_data_rd_i | m_data_wr_i);
  assign w_mis = w_acc & (((m_data_be_i == BE_HALF) & m_data_addr_i[0]) |
                          ((m_data_be_i == BE_WORD) & (m_data_addr_i[1:0] != 2'b00)));
  // r_done blocks a re-request once the access finished under an external stall.
  assign w_active  = w_acc & ~w_mis & ~r_done;
  assign w_is_load = w_acc & ~m_data_wr_i & ~w_mis;

  assign data_addr_o  = {m_data_addr_i[DATA_WIDTH-1:2], 2'b00};
  assign data_we_o    = m_data_wr_i;
  assign data_be_o    = m_data_be_i << m_data_addr_i[1:0];
  assign data_wdata_o = m_regfile_rd_i << {m_data_addr_i[1:0], 3'b000};

  mem_stage_load_align u_load_align (
    .i_rdata (data_rdata_i),
    .i_off   (m_data_addr_i[1:0]),
    .i_op    (m_LOAD_op_i),
    .o_data  (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MEM_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    data_req_o  = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        data_req_o = w_active;
        if (w_active && data_gnt_i) begin
          if (m_data_wr_i) w_complete  = 1'b1;
          else             w_state_nxt = MEM_WAIT_RV;
        end
      end
      MEM_WAIT_RV: begin
        if (data_rvalid_i) begin
          w_complete  = 1'b1;
          w_state_nxt = MEM_IDLE;
        end
      end
      default: w_state_nxt = MEM_IDLE;
    endcase
  end

  assign mem_stall_o = w_active & ~w_complete;

  // Completion during someone else's stall is remembered until the pipe moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_load_buf <= '0;
    end else if (stall_general_i) begin
      if (w_complete) r_done <= 1'b1;
      if (w_complete && !m_data_wr_i) r_load_buf <= w_load_data;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign w_wb_data = w_is_load ? (r_done ? r_load_buf : w_load_data) : m_regfile_rd_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_regfile_waddr_o <= '0;
      w_regfile_wdata_o <= '0;
      w_regfile_wr_o    <= 1'b0;
      misaligned_o      <= 1'b0;
    end else if (!stall_general_i) begin
      w_regfile_waddr_o <= m_regfile_waddr_i;
      w_regfile_wdata_o <= w_wb_data;
      w_regfile_wr_o    <= m_regfile_wr_i & ~w_mis;
      misaligned_o      <= w_mis;
    end else begin
      w_regfile_wr_o <= 1'b0;
      misaligned_o   <= 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage. Consumes its registered m_* outputs and drives a req/gnt/rvalid data-memory bus.
- Aligns store data and byte enables to the addressed byte lane, and selects plus sign/zero-extends load data.
- Registers the write-back triple for the register file.
- Raises a stall while a memory transaction is outstanding.

Parameters:
DATA_WIDTH, 32, datapath width (only 32 supported)
BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
m_regfile_waddr_i  in  5  destination register
m_regfile_rd_i  in  32  ALU/PC result, or zero-extended store data for stores
m_regfile_wr_i  in  1  register write enable
m_data_wr_i  in  1  store request
m_data_rd_i  in  1  load request
m_is_load_store_i  in  1  instruction is a memory access
m_data_addr_i  in  32  effective byte address
m_data_be_i  in  4  lane-0-relative byte enables (0001 byte, 0011 half, 1111 word)
m_LOAD_op_i  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
stall_general_i  in  1  global stall (OR of all stall sources, including mem_stall_o)
mem_stall_o  out  1  memory access not yet complete
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  32  word address {addr[31:2],2'b00}
data_we_o  out  1  1 = write
data_be_o  out  4  lane-shifted byte enables
data_wdata_o  out  32  lane-shifted store data
data_rvalid_i  in  1  read data valid
data_rdata_i  in  32  read data
w_regfile_waddr_o  out  5  WB destination
w_regfile_wdata_o  out  32  WB data
w_regfile_wr_o  out  1  WB write enable
misaligned_o  out  1  registered misaligned-access flag, aligned with WB

Behaviour:
- Reset: FSM=IDLE, done_q=0, load buffer=0. All registered outputs are 0. Reset mid-transaction drops data_req_o immediately. An rvalid arriving after reset is ignored.
- Access present: acc = m_is_load_store_i & (m_data_rd_i | m_data_wr_i).
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0. A misaligned access issues no request and no stall. WB gets wr=0 and misaligned_o=1 for one cycle.
- Store alignment: data_be_o = m_data_be_i << addr[1:0]. data_wdata_o = m_regfile_rd_i << (8*addr[1:0]).
- FSM states:
  - IDLE: data_req_o = acc & aligned & !done_q.
    - gnt with a store: complete this cycle.
    - gnt with a load: go to WAIT_RV.
    - no gnt: hold the request; address and data stay stable because upstream is stalled.
  - WAIT_RV: data_req_o=0.
    - rvalid: extract lane addr[1:0], extend per LOAD_op, complete this cycle. Data passes through combinationally to the WB mux.
    - rvalid arriving in the same cycle as gnt is not allowed; the bus guarantees rvalid at least 1 cycle after gnt.
- mem_stall_o = acc & aligned & !done_q & !complete_this_cycle. Minimum store latency 0 extra cycles (gnt same cycle). Minimum load latency 1 stall cycle.
- Completion while stall_general_i=1 (another stage stalling): set done_q and store the load result in the buffer. Return to IDLE, issue no re-request, and take the buffered data for WB. Clear done_q on the first cycle with stall_general_i=0.
- WB register:
  - stall_general_i=0: load {waddr, wdata, wr}. wdata = load result for loads, otherwise m_regfile_rd_i. wr = m_regfile_wr_i & !misaligned.
  - stall_general_i=1: hold waddr/wdata and force w_regfile_wr_o=0, so each instruction writes exactly once.
- Zero-register writes are passed through unchanged; the register file ignores x0.

Decomposition:
- Shared defines header gets the LOAD_LB/LH/LW/LBU/LHU encodings, the BE_BYTE/HALF/WORD constants and the mem FSM state encodings.
- One sub-module is natural: load_align, a combinational lane select plus sign/zero extend from (rdata, addr[1:0], LOAD_op).

Test Plan:
- SW addr 0x100, rd_i 0xDEADBEEF, gnt same cycle -> req=1, be=1111, wdata=0xDEADBEEF, mem_stall_o=0, WB wr follows m_regfile_wr_i (0).
- SB addr 0x103, rd_i 0x000000A5 -> be=1000, wdata=0xA5000000, data_addr_o=0x100.
- LB addr 0x102, gnt after 2 cycles, rvalid 1 cycle later, rdata 0x1280FF00 -> 3 stall cycles, WB wdata=0xFFFFFF80. Same with LBU -> 0x00000080.
- LH addr 0x101 -> no req, no stall, misaligned_o=1 for one cycle, w_regfile_wr_o=0.
- LW completes while stall_general_i held high 3 more cycles -> exactly one req and one gnt, rdata buffered, WB captures it when stall drops, w_regfile_wr_o high exactly 1 cycle.
- rst_n asserted in WAIT_RV, rvalid arrives after release -> req=0, FSM IDLE, no WB write.
